// File: rtl/pwm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pwm_pkg                                                         |
// | Purpose  : Shared PWM definitions: default sample width, period helper     |
// |            and the state encoding common to the PWM transmitter and the    |
// |            demodulator.                                                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package pwm_pkg;

  // Default sample width; a PWM period is 2^PWM_WIDTH clocks.
  localparam int PWM_WIDTH = 12;

  // Shared state encoding for the PWM transmitter / demodulator pair.
  typedef enum logic [1:0] {
    PWM_IDLE     = 2'd0,
    PWM_MEASURE  = 2'd1,
    PWM_LOW_HOLD = 2'd2
  } pwm_state_e;

  // Nominal period length in clocks for a given sample width (width <= 31).
  function automatic int unsigned pwm_period(input int unsigned width);
    return 32'd1 << width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_demod_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pwm_demod_if                                                    |
// | Purpose  : Bundles the PWM bitstream input and the recovered-sample        |
// |            outputs of the demodulator.                                     |
// | Ports    : pwm_in       - asynchronous PWM bitstream                       |
// |            sample_out   - recovered signed sample (WIDTH bits)             |
// |            sample_valid - one-cycle pulse when sample_out updates          |
// |            locked       - high while periods measure exactly 2^WIDTH       |
// |            period_err   - one-cycle pulse on a malformed period            |
// | Modports : master - demodulator side, slave - source/consumer side         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface pwm_demod_if
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
);

  logic             pwm_in;
  logic [WIDTH-1:0] sample_out;
  logic             sample_valid;
  logic             locked;
  logic             period_err;

  modport master (
    input  pwm_in,
    output sample_out,
    output sample_valid,
    output locked,
    output period_err
  );

  modport slave (
    output pwm_in,
    input  sample_out,
    input  sample_valid,
    input  locked,
    input  period_err
  );

endinterface
`default_nettype wire

// File: rtl/pwm_sync_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pwm_sync_edge                                                   |
// | Purpose  : Synchronizes the asynchronous PWM input and flags rising edges. |
// | Ports    : clk, rst_n - clock and asynchronous active-low reset            |
// |            async_in   - raw asynchronous input                             |
// |            s          - synchronized level, aligned with rise              |
// |            rise       - registered one-cycle rising-edge pulse             |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2   // minimum 2
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic async_in,
  output logic      s,
  output logic      rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_q, s_d;
  logic                   rise_q, rise_d;

  // s_q holds the previous synchronized level; s and rise are both taken
  // from flops so the consumer sees s=1 in the same cycle rise is high.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    s_d    = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~s_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_q    <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      s_q    <= s_d;
      rise_q <= rise_d;
    end
  end

  assign s    = s_q;
  assign rise = rise_q;

endmodule
`default_nettype wire

// File: rtl/pwm_demod.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : pwm_demod                                                       |
// | Purpose  : Recovers signed samples from a fixed-period PWM bitstream by    |
// |            measuring the high time of each 2^WIDTH-clock period.           |
// | Ports    : clk   - single clock                                            |
// |            rst_n - asynchronous active-low reset                           |
// |            bus   - pwm_demod_if.master (pwm_in in; sample_out,            |
// |                    sample_valid, locked, period_err out)                   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module pwm_demod
  import pwm_pkg::*;
#(
  parameter int WIDTH       = PWM_WIDTH,  // 2..31
  parameter int SYNC_STAGES = 2           // minimum 2
) (
  input  wire logic    clk,
  input  wire logic    rst_n,
  pwm_demod_if.master  bus
);

  localparam logic [WIDTH:0]   c_period     = (WIDTH+1)'(pwm_period(unsigned'(WIDTH)));
  localparam logic [WIDTH:0]   c_cnt_one    = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] c_high_one   = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_min_sample = {1'b1, {(WIDTH-1){1'b0}}};

  logic w_s, w_rise;

  pwm_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (bus.pwm_in),
    .s        (w_s),
    .rise     (w_rise)
  );

  pwm_state_e       state_q, state_d;
  logic [WIDTH:0]   period_cnt_q, period_cnt_d;
  // A valid period has at most 2^WIDTH-1 high cycles, so WIDTH bits suffice.
  logic [WIDTH-1:0] high_cnt_q, high_cnt_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   w_period_inc;
  logic [WIDTH-1:0] w_high_inc;

  // Saturating increments: counters stick at all-ones instead of wrapping.
  assign w_period_inc = (&period_cnt_q) ? period_cnt_q : period_cnt_q + 1'b1;
  assign w_high_inc   = (&high_cnt_q)   ? high_cnt_q   : high_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    period_cnt_d = w_period_inc;
    high_cnt_d   = w_s ? w_high_inc : high_cnt_q;
    sample_d     = sample_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;
    locked_d     = locked_q;

    case (state_q)
      PWM_IDLE: begin
        period_cnt_d = '0;
        high_cnt_d   = '0;
        if (w_rise) begin
          state_d      = PWM_MEASURE;
          period_cnt_d = c_cnt_one;
          high_cnt_d   = c_high_one;
        end
      end

      PWM_MEASURE: begin
        if (w_rise) begin
          // Every edge closes the running period and opens a new one.
          period_cnt_d = c_cnt_one;
          high_cnt_d   = c_high_one;
          if (period_cnt_q == c_period) begin
            // Offset-binary to two's complement: invert the MSB.
            sample_d = {~high_cnt_q[WIDTH-1], high_cnt_q[WIDTH-2:0]};
            valid_d  = 1'b1;
            locked_d = 1'b1;
          end else begin
            err_d    = 1'b1;
            locked_d = 1'b0;
          end
        end else if (period_cnt_q > c_period) begin
          // Overran the period without an edge: input stuck high.
          err_d        = 1'b1;
          locked_d     = 1'b0;
          state_d      = PWM_IDLE;
          period_cnt_d = '0;
          high_cnt_d   = '0;
        end else if (period_cnt_q == c_period && !w_s) begin
          high_cnt_d = '0;
          if (locked_q) begin
            // Input dropped to constant low: report full negative scale.
            sample_d     = c_min_sample;
            valid_d      = 1'b1;
            state_d      = PWM_LOW_HOLD;
            period_cnt_d = c_cnt_one;
          end else begin
            state_d      = PWM_IDLE;
            period_cnt_d = '0;
          end
        end
      end

      PWM_LOW_HOLD: begin
        high_cnt_d = '0;
        if (w_rise) begin
          state_d      = PWM_MEASURE;
          period_cnt_d = c_cnt_one;
          high_cnt_d   = c_high_one;
        end else if (period_cnt_q == c_period) begin
          sample_d     = c_min_sample;
          valid_d      = 1'b1;
          period_cnt_d = c_cnt_one;
        end
      end

      default: begin
        state_d      = PWM_IDLE;
        period_cnt_d = '0;
        high_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= PWM_IDLE;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      sample_q     <= '0;
      valid_q      <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      sample_q     <= sample_d;
      valid_q      <= valid_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
    end
  end

  assign bus.sample_out   = sample_q;
  assign bus.sample_valid = valid_q;
  assign bus.locked       = locked_q;
  assign bus.period_err   = err_q;

endmodule
`default_nettype wire

// File: doc/pwm_demod.md
PWM_DEMOD -- requirements
Module: pwm_demod

Interface
REQ-001 SHALL have parameter WIDTH, default 12: sample width; nominal PWM period is 2^WIDTH clocks.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: input synchronizer depth (minimum 2).
REQ-003 SHALL have port clk, input, 1: single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port pwm_in, input, 1: asynchronous PWM bitstream.
REQ-006 SHALL have port sample_out, output, WIDTH: recovered signed two's-complement sample.
REQ-007 SHALL have port sample_valid, output, 1: one-cycle pulse when sample_out updates.
REQ-008 SHALL have port locked, output, 1: high while consecutive periods measure exactly 2^WIDTH.
REQ-009 SHALL have port period_err, output, 1: one-cycle pulse on a malformed period.

Function
REQ-010 SHALL pass pwm_in through SYNC_STAGES flops; all logic SHALL use the synchronized value s.
REQ-011 SHALL define a rising edge as s=1 with the previous s=0, and SHALL treat each rising edge as a period start.
REQ-012 SHALL implement states IDLE, MEASURE and LOW_HOLD.
- IDLE: wait for the first edge, then go to MEASURE.
- MEASURE: count the period.
- LOW_HOLD: input held low.
REQ-013 In MEASURE, the period counter (WIDTH+1 bits) SHALL load 1 on the edge cycle and then increment each cycle.
REQ-014 In MEASURE, the high counter SHALL load 1 on the edge cycle and then increment on each cycle with s=1.
REQ-015 On an edge in MEASURE with period count = 2^WIDTH, the block SHALL register sample_out = high_count[WIDTH-1:0] with the MSB inverted (that is, high_count - 2^(WIDTH-1)), pulse sample_valid, and set locked.
REQ-016 On an edge in MEASURE with period count ≠ 2^WIDTH, the block SHALL pulse period_err, clear locked, and leave sample_out unchanged.
REQ-017 In every case an edge SHALL restart both counters (new period begins).
REQ-018 If the period count reaches 2^WIDTH with no edge and s=0:
- while locked, the block SHALL emit sample_out = 2^(WIDTH-1) as a two's-complement minimum (0x800 for WIDTH=12), pulse sample_valid, go to LOW_HOLD, and stay locked;
- while not locked, it SHALL go to IDLE.
REQ-019 In LOW_HOLD:
- the block SHALL repeat the 0x800 sample with sample_valid every 2^WIDTH cycles;
- an edge SHALL go to MEASURE with counters loaded per REQ-013/014.
REQ-020 If the period count exceeds 2^WIDTH with no edge and s=1, the block SHALL pulse period_err, clear locked, and go to IDLE.
REQ-021 The counter SHALL saturate and never wrap.
REQ-022 Latency: sample_out/sample_valid SHALL appear exactly SYNC_STAGES+2 clocks after the pwm_in rising edge that closes the period.
REQ-023 sample_valid and period_err SHALL never be asserted in the same cycle.

Reset
REQ-024 While rst_n=0, the block SHALL hold state=IDLE, sample_out=0, sample_valid=0, locked=0, period_err=0, all counters and synchronizer flops at 0.
REQ-025 Reset asserted mid-period SHALL discard the partial measurement.
REQ-026 After reset deassertion, the first edge SHALL only start a period (no sample emitted).

Structure
REQ-027 Package pwm_pkg SHALL hold the default PWM_WIDTH, a PERIOD = 2^WIDTH helper, and the state enumeration shared with the PWM transmitter.
REQ-028 Sub-module pwm_sync_edge SHALL contain the synchronizer and the rising-edge detector, and SHALL output s and rise.
REQ-029 All outputs SHALL be driven from flops.

Verification
REQ-030 Periodic 4096-clock PWM, high 2048 cycles -> after the second edge, sample_out=0x000, sample_valid pulse, locked=1.
REQ-031 High 1 cycle per period -> sample_out=0x801; high 4095 cycles -> sample_out=0x7FF; one valid per period.
REQ-032 Locked stream, then pwm_in held low for 3 periods -> sample_out=0x800 with valid every 4096 clocks, locked stays 1; resuming PWM at high 1024 -> sample_out=0xC00.
REQ-033 Period shortened to 4000 clocks -> period_err pulse, locked=0, sample_out unchanged; after two good periods -> locked=1.
REQ-034 pwm_in stuck high for more than 4096 clocks -> period_err pulse, locked=0, state IDLE.
REQ-035 rst_n pulsed low mid-period -> all outputs 0 immediately; the first post-reset edge emits no sample; valid resumes on the next edge.
